s2p_deserializer: RTL

- Serial-to-parallel receiver: takes one bit per clock, LSB-first, from the proyecto-01 p2s serializer and rebuilds 8-bit bytes.
- Bit-level search for the COM control symbol aligns byte boundaries; COM_COUNT consecutive aligned COMs declare the link active.
- Only non-COM bytes are then forwarded downstream as valid data.
- Sits at the receive end of the serial link, feeding the byte/lane logic.

---
 rtl/s2p_deserializer_if.sv | 22 ++
 rtl/s2p_deserializer.sv | 112 +++++++++++
 2 files changed

// File: rtl/s2p_deserializer_if.sv
// Serial receive bundle: one serial bit in, recovered byte stream and link status out.
interface s2p_deserializer_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active_out;

    // master drives the serial line and observes the recovered bytes
    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active_out
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active_out
    );
endinterface

// File: rtl/s2p_deserializer.sv
// LSB-first serial-to-parallel receiver: bit-level COM search, byte alignment by
// COM_COUNT consecutive aligned COMs, then forwarding of non-COM bytes.
module s2p_deserializer #(
    parameter logic [7:0]  COM       = 8'hBC,
    parameter int unsigned COM_COUNT = 4
) (
    input  logic                 clk,
    input  logic                 reset_L,
    s2p_deserializer_if.slave    bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       active_q, active_d;

    logic [7:0] win;
    logic       is_com;
    logic       boundary;

    // Newest bit enters at the top, so after 8 shifts the oldest bit is win[0].
    assign win      = {bus.data_in, sr_q[7:1]};
    assign is_com   = (win == COM);
    assign boundary = (bit_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= SEARCH;
            sr_q      <= 8'h00;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = win;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;

        case (state_q)
            SEARCH: begin
                // Phase is meaningless until a COM is seen; the COM's last bit
                // defines the next boundary 8 bits later.
                bit_cnt_d = 3'd0;
                if (is_com) begin
                    com_cnt_d = 4'd1;
                    state_d   = (COM_TARGET == 4'd1) ? ACTIVE : ALIGN;
                end
            end

            ALIGN: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_d == COM_TARGET) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        com_cnt_d = 4'd0;
                        state_d   = SEARCH;
                    end
                end
            end

            ACTIVE: begin
                // COMs are idles: data_out keeps the last real byte.
                if (boundary && !is_com) begin
                    data_d  = win;
                    valid_d = 1'b1;
                end
            end

            default: begin
                state_d   = SEARCH;
                com_cnt_d = 4'd0;
                bit_cnt_d = 3'd0;
            end
        endcase
    end

    assign active_d = (state_d == ACTIVE);

    assign bus.data_out   = data_q;
    assign bus.valid_out  = valid_q;
    assign bus.active_out = active_q;

endmodule
